// File: rtl/branch_decode_stage.sv
// Branch/jump decode stage: per-lane decode of B/BL/JIRL/Bcc, killing of lanes behind
// an early-redirected B/BL, and a one-cycle fetch redirect pulse toward its target.
`ifndef ALU_NOP
`define ALU_NOP 8'h00
`endif
`ifndef ALU_BEQ
`define ALU_BEQ 8'h50
`endif
`ifndef ALU_BNE
`define ALU_BNE 8'h51
`endif
`ifndef ALU_BLT
`define ALU_BLT 8'h52
`endif
`ifndef ALU_BGE
`define ALU_BGE 8'h53
`endif
`ifndef ALU_BLTU
`define ALU_BLTU 8'h54
`endif
`ifndef ALU_BGEU
`define ALU_BGEU 8'h55
`endif
`ifndef ALU_B
`define ALU_B 8'h56
`endif
`ifndef ALU_BL
`define ALU_BL 8'h57
`endif
`ifndef ALU_JIRL
`define ALU_JIRL 8'h58
`endif
`ifndef ALU_SEL_NOP
`define ALU_SEL_NOP 3'b000
`endif
`ifndef ALU_SEL_JUMP_BRANCH
`define ALU_SEL_JUMP_BRANCH 3'b101
`endif

module branch_decode_stage #(
  parameter int DECODE_WIDTH      = 2,
  parameter bit EN_EARLY_REDIRECT = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DECODE_WIDTH-1:0]     in_lane_valid,
  input  logic [32*DECODE_WIDTH-1:0]  in_pc,
  input  logic [32*DECODE_WIDTH-1:0]  in_inst,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DECODE_WIDTH-1:0]     out_lane_valid,
  output logic [32*DECODE_WIDTH-1:0]  out_pc,
  output logic [32*DECODE_WIDTH-1:0]  out_inst,
  output logic [8*DECODE_WIDTH-1:0]   out_aluop,
  output logic [3*DECODE_WIDTH-1:0]   out_alusel,
  output logic [32*DECODE_WIDTH-1:0]  out_imm,
  output logic [DECODE_WIDTH-1:0]     out_reg1_read_en,
  output logic [DECODE_WIDTH-1:0]     out_reg2_read_en,
  output logic [DECODE_WIDTH-1:0]     out_reg_write_en,
  output logic [5*DECODE_WIDTH-1:0]   out_reg1_addr,
  output logic [5*DECODE_WIDTH-1:0]   out_reg2_addr,
  output logic [5*DECODE_WIDTH-1:0]   out_reg_write_addr,
  output logic [DECODE_WIDTH-1:0]     out_is_exception,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc
);

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  logic                        w_accept;
  logic                        w_redirect_any;
  logic [31:0]                 w_redirect_pc;
  logic [DECODE_WIDTH-1:0]     w_is_bbl;
  logic [DECODE_WIDTH-1:0]     w_live;
  logic [32*DECODE_WIDTH-1:0]  w_tgt;
  logic [8*DECODE_WIDTH-1:0]   w_aluop;
  logic [3*DECODE_WIDTH-1:0]   w_alusel;
  logic [32*DECODE_WIDTH-1:0]  w_imm;
  logic [DECODE_WIDTH-1:0]     w_r1e, w_r2e, w_we, w_exc;
  logic [5*DECODE_WIDTH-1:0]   w_r1a, w_r2a, w_wa;

  logic                        r_out_valid;
  logic [DECODE_WIDTH-1:0]     r_lane_valid;
  logic [32*DECODE_WIDTH-1:0]  r_pc, r_inst, r_imm;
  logic [8*DECODE_WIDTH-1:0]   r_aluop;
  logic [3*DECODE_WIDTH-1:0]   r_alusel;
  logic [DECODE_WIDTH-1:0]     r_r1e, r_r2e, r_we, r_exc;
  logic [5*DECODE_WIDTH-1:0]   r_r1a, r_r2a, r_wa;
  logic                        r_redirect_valid;
  logic [31:0]                 r_redirect_pc;

  assign in_ready = rst_n && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < DECODE_WIDTH; gi++) begin : g_lane
      logic [31:0] w_ins, w_pc, w_off16, w_off26;
      logic [5:0]  w_op;
      logic [7:0]  w_d_aluop;
      logic [2:0]  w_d_alusel;
      logic [31:0] w_d_imm;
      logic        w_d_r1e, w_d_r2e, w_d_we, w_d_exc, w_d_bbl;
      logic [4:0]  w_d_r1a, w_d_r2a, w_d_wa;

      assign w_ins   = in_inst[32*gi +: 32];
      assign w_pc    = in_pc[32*gi +: 32];
      assign w_op    = w_ins[31:26];
      assign w_off16 = {{14{w_ins[25]}}, w_ins[25:10], 2'b00};
      assign w_off26 = {{4{w_ins[9]}}, w_ins[9:0], w_ins[25:10], 2'b00};

      always_comb begin
        w_d_aluop  = `ALU_NOP;
        w_d_alusel = `ALU_SEL_NOP;
        w_d_imm    = '0;
        w_d_r1e    = 1'b0;
        w_d_r2e    = 1'b0;
        w_d_we     = 1'b0;
        w_d_r1a    = '0;
        w_d_r2a    = '0;
        w_d_wa     = '0;
        w_d_exc    = 1'b0;
        w_d_bbl    = 1'b0;
        case (w_op)
          OP_JIRL: begin
            w_d_aluop  = `ALU_JIRL;
            w_d_alusel = `ALU_SEL_JUMP_BRANCH;
            w_d_imm    = w_off16;
            w_d_r1e    = 1'b1;
            w_d_r1a    = w_ins[9:5];
            w_d_we     = 1'b1;
            w_d_wa     = w_ins[4:0];
          end
          OP_B, OP_BL: begin
            w_d_aluop  = (w_op == OP_BL) ? `ALU_BL : `ALU_B;
            w_d_alusel = `ALU_SEL_JUMP_BRANCH;
            w_d_imm    = w_off26;
            w_d_we     = (w_op == OP_BL);
            w_d_wa     = (w_op == OP_BL) ? 5'd1 : 5'd0;
            w_d_bbl    = 1'b1;
          end
          OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            case (w_op)
              OP_BEQ:  w_d_aluop = `ALU_BEQ;
              OP_BNE:  w_d_aluop = `ALU_BNE;
              OP_BLT:  w_d_aluop = `ALU_BLT;
              OP_BGE:  w_d_aluop = `ALU_BGE;
              OP_BLTU: w_d_aluop = `ALU_BLTU;
              default: w_d_aluop = `ALU_BGEU;
            endcase
            w_d_alusel = `ALU_SEL_JUMP_BRANCH;
            w_d_imm    = w_off16;
            w_d_r1e    = 1'b1;
            w_d_r2e    = 1'b1;
            w_d_r1a    = w_ins[9:5];
            w_d_r2a    = w_ins[4:0];
          end
          default: w_d_exc = 1'b1;
        endcase
      end

      assign w_is_bbl[gi]           = w_d_bbl;
      assign w_tgt[32*gi +: 32]     = w_pc + w_off26;
      // Dead or killed lanes present an all-zero control word.
      assign w_aluop[8*gi +: 8]     = w_live[gi] ? w_d_aluop  : '0;
      assign w_alusel[3*gi +: 3]    = w_live[gi] ? w_d_alusel : '0;
      assign w_imm[32*gi +: 32]     = w_live[gi] ? w_d_imm    : '0;
      assign w_r1e[gi]              = w_live[gi] & w_d_r1e;
      assign w_r2e[gi]              = w_live[gi] & w_d_r2e;
      assign w_we[gi]               = w_live[gi] & w_d_we;
      assign w_exc[gi]              = w_live[gi] & w_d_exc;
      assign w_r1a[5*gi +: 5]       = w_live[gi] ? w_d_r1a : '0;
      assign w_r2a[5*gi +: 5]       = w_live[gi] ? w_d_r2a : '0;
      assign w_wa[5*gi +: 5]        = w_live[gi] ? w_d_wa  : '0;
    end
  endgenerate

  // Lowest valid B/BL wins the redirect and kills every lane above it.
  always_comb begin
    logic w_seen;
    w_seen        = 1'b0;
    w_redirect_pc = '0;
    w_live        = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      w_live[i] = in_lane_valid[i] && !(EN_EARLY_REDIRECT && w_seen);
      if (in_lane_valid[i] && w_is_bbl[i] && !w_seen) begin
        w_redirect_pc = w_tgt[32*i +: 32];
        w_seen        = 1'b1;
      end
    end
    w_redirect_any = EN_EARLY_REDIRECT && w_seen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_lane_valid     <= '0;
      r_pc             <= '0;
      r_inst           <= '0;
      r_imm            <= '0;
      r_aluop          <= '0;
      r_alusel         <= '0;
      r_r1e            <= '0;
      r_r2e            <= '0;
      r_we             <= '0;
      r_exc            <= '0;
      r_r1a            <= '0;
      r_r2a            <= '0;
      r_wa             <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else if (flush) begin
      r_out_valid      <= 1'b0;
      r_lane_valid     <= '0;
      r_redirect_valid <= 1'b0;
    end else begin
      r_redirect_valid <= w_accept && w_redirect_any;
      if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_lane_valid <= w_live;
        r_pc         <= in_pc;
        r_inst       <= in_inst;
        r_imm        <= w_imm;
        r_aluop      <= w_aluop;
        r_alusel     <= w_alusel;
        r_r1e        <= w_r1e;
        r_r2e        <= w_r2e;
        r_we         <= w_we;
        r_exc        <= w_exc;
        r_r1a        <= w_r1a;
        r_r2a        <= w_r2a;
        r_wa         <= w_wa;
        if (w_redirect_any) r_redirect_pc <= w_redirect_pc;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid          = r_out_valid;
  assign out_lane_valid     = r_lane_valid;
  assign out_pc             = r_pc;
  assign out_inst           = r_inst;
  assign out_aluop          = r_aluop;
  assign out_alusel         = r_alusel;
  assign out_imm            = r_imm;
  assign out_reg1_read_en   = r_r1e;
  assign out_reg2_read_en   = r_r2e;
  assign out_reg_write_en   = r_we;
  assign out_reg1_addr      = r_r1a;
  assign out_reg2_addr      = r_r2a;
  assign out_reg_write_addr = r_wa;
  assign out_is_exception   = r_exc;
  assign redirect_valid     = r_redirect_valid;
  assign redirect_pc        = r_redirect_pc;

endmodule

// File: tb/tb_branch_decode_stage.sv
// Scoreboard bench for branch_decode_stage (2 lanes, early redirect on): expected
// bundles are queued at accept and compared every cycle they are presented.
module tb_branch_decode_stage;

  localparam logic [7:0] A_NOP  = 8'h00, A_BEQ = 8'h50, A_BNE = 8'h51, A_BLT = 8'h52;
  localparam logic [7:0] A_BGE  = 8'h53, A_BLTU = 8'h54, A_BGEU = 8'h55;
  localparam logic [7:0] A_B    = 8'h56, A_BL = 8'h57, A_JIRL = 8'h58;
  localparam logic [2:0] SEL_JB = 3'b101;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, redirect_valid;
  logic [1:0]  in_lane_valid = '0;
  logic [63:0] in_pc = '0, in_inst = '0;
  logic [1:0]  out_lane_valid, out_reg1_read_en, out_reg2_read_en, out_reg_write_en, out_is_exception;
  logic [63:0] out_pc, out_inst, out_imm;
  logic [15:0] out_aluop;
  logic [5:0]  out_alusel;
  logic [9:0]  out_reg1_addr, out_reg2_addr, out_reg_write_addr;
  logic [31:0] redirect_pc;

  branch_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_aluop(out_aluop), .out_alusel(out_alusel),
    .out_imm(out_imm), .out_reg1_read_en(out_reg1_read_en), .out_reg2_read_en(out_reg2_read_en),
    .out_reg_write_en(out_reg_write_en), .out_reg1_addr(out_reg1_addr),
    .out_reg2_addr(out_reg2_addr), .out_reg_write_addr(out_reg_write_addr),
    .out_is_exception(out_is_exception), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  lv;
    logic [15:0] aluop;
    logic [5:0]  alusel;
    logic [63:0] imm;
    logic [1:0]  r1e, r2e, we;
    logic [9:0]  r1a, r2a, wa;
    logic [1:0]  exc;
    logic [63:0] pc, inst;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0, n_chk = 0, n_txn = 0;
  bit   m_ov = 1'b0, m_fresh = 1'b0, m_flushed = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc16(input logic [5:0] op, input logic [15:0] off,
                                        input logic [4:0] rj, input logic [4:0] rd);
    return {op, off, rj, rd};
  endfunction

  function automatic logic [31:0] enc26(input logic [5:0] op, input logic [25:0] off);
    return {op, off[15:0], off[25:16]};
  endfunction

  function automatic exp_t f_model(input logic [1:0] lv, input logic [63:0] pc, input logic [63:0] inst);
    exp_t e;
    bit   seen;
    e    = '0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] w, i16, i26;
      logic [5:0]  op;
      logic signed [31:0] s16, s26;
      bit live, isbr;
      w    = inst[32*i +: 32];
      op   = w[31:26];
      s16  = 32'($signed(w[25:10]));
      s26  = 32'($signed({w[9:0], w[25:10]}));
      i16  = s16 * 4;
      i26  = s26 * 4;
      live = lv[i] && !seen;
      isbr = (op == 6'h14) || (op == 6'h15);
      e.lv[i] = live;
      if (live) begin
        case (op)
          6'h13: begin
            e.aluop[8*i +: 8] = A_JIRL; e.alusel[3*i +: 3] = SEL_JB; e.imm[32*i +: 32] = i16;
            e.r1e[i] = 1'b1; e.r1a[5*i +: 5] = w[9:5]; e.we[i] = 1'b1; e.wa[5*i +: 5] = w[4:0];
          end
          6'h14: begin
            e.aluop[8*i +: 8] = A_B; e.alusel[3*i +: 3] = SEL_JB; e.imm[32*i +: 32] = i26;
          end
          6'h15: begin
            e.aluop[8*i +: 8] = A_BL; e.alusel[3*i +: 3] = SEL_JB; e.imm[32*i +: 32] = i26;
            e.we[i] = 1'b1; e.wa[5*i +: 5] = 5'd1;
          end
          6'h16, 6'h17, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
            case (op)
              6'h16:   e.aluop[8*i +: 8] = A_BEQ;
              6'h17:   e.aluop[8*i +: 8] = A_BNE;
              6'h18:   e.aluop[8*i +: 8] = A_BLT;
              6'h19:   e.aluop[8*i +: 8] = A_BGE;
              6'h1A:   e.aluop[8*i +: 8] = A_BLTU;
              default: e.aluop[8*i +: 8] = A_BGEU;
            endcase
            e.alusel[3*i +: 3] = SEL_JB; e.imm[32*i +: 32] = i16;
            e.r1e[i] = 1'b1; e.r2e[i] = 1'b1; e.r1a[5*i +: 5] = w[9:5]; e.r2a[5*i +: 5] = w[4:0];
          end
          default: e.exc[i] = 1'b1;
        endcase
      end
      if (lv[i] && isbr && !seen) begin
        e.rv  = 1'b1;
        e.rpc = pc[32*i +: 32] + i26;
        seen  = 1'b1;
      end
    end
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    check_val("out_valid", out_valid, m_ov);
    if (m_ov) begin
      e = sb[0];
      check_val("lane_valid", out_lane_valid, e.lv);
      check_val("aluop", out_aluop, e.aluop);
      check_val("alusel", out_alusel, e.alusel);
      check_val("imm", out_imm, e.imm);
      check_val("reg1_read_en", out_reg1_read_en, e.r1e);
      check_val("reg2_read_en", out_reg2_read_en, e.r2e);
      check_val("reg_write_en", out_reg_write_en, e.we);
      check_val("reg1_addr", out_reg1_addr, e.r1a);
      check_val("reg2_addr", out_reg2_addr, e.r2a);
      check_val("reg_write_addr", out_reg_write_addr, e.wa);
      check_val("is_exception", out_is_exception, e.exc);
      check_val("out_pc", out_pc, e.pc);
      check_val("out_inst", out_inst, e.inst);
      check_val("redirect_valid", redirect_valid, m_fresh && e.rv);
      if (m_fresh && e.rv) check_val("redirect_pc", redirect_pc, e.rpc);
    end else begin
      check_val("redirect_valid_idle", redirect_valid, 1'b0);
      if (m_flushed) check_val("lane_valid_cleared", out_lane_valid, 2'b00);
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks the result one edge later.
  task automatic step(input bit f, input bit iv, input bit ordy, input logic [1:0] lv,
                      input logic [63:0] pc, input logic [63:0] inst);
    bit acc;
    flush = f; in_valid = iv; out_ready = ordy; in_lane_valid = lv; in_pc = pc; in_inst = inst;
    #1;
    check_val("in_ready", in_ready, !m_ov || ordy);
    acc = iv && (!m_ov || ordy) && !f;
    if (f) begin
      if (m_ov) void'(sb.pop_front());
      m_ov = 1'b0; m_fresh = 1'b0; m_flushed = 1'b1;
    end else begin
      if (m_ov && ordy) begin
        void'(sb.pop_front());
        m_ov = 1'b0;
      end
      m_fresh = 1'b0;
      if (acc) begin
        sb.push_back(f_model(lv, pc, inst));
        m_ov = 1'b1; m_fresh = 1'b1; m_flushed = 1'b0;
        n_txn++;
        $display("txn %0d: accept lanes=%b pc=%h inst=%h", n_txn, lv, pc, inst);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_zero(input string ctx);
    check_val({ctx, "_out_valid"}, out_valid, 1'b0);
    check_val({ctx, "_in_ready"}, in_ready, 1'b0);
    check_val({ctx, "_lane_valid"}, out_lane_valid, 2'b00);
    check_val({ctx, "_aluop"}, out_aluop, 16'h0);
    check_val({ctx, "_imm"}, out_imm, 64'h0);
    check_val({ctx, "_pc"}, out_pc, 64'h0);
    check_val({ctx, "_write_en"}, out_reg_write_en, 2'b00);
    check_val({ctx, "_exception"}, out_is_exception, 2'b00);
    check_val({ctx, "_redirect_valid"}, redirect_valid, 1'b0);
    check_val({ctx, "_redirect_pc"}, redirect_pc, 32'h0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] op;
    case ($urandom_range(0, 10))
      0: op = 6'h13;  1: op = 6'h14;  2: op = 6'h15;  3: op = 6'h16;
      4: op = 6'h17;  5: op = 6'h18;  6: op = 6'h19;  7: op = 6'h1A;
      8: op = 6'h1B;  9: op = 6'h00;  default: op = 6'h3F;
    endcase
    return {op, 26'($urandom)};
  endfunction

  logic [31:0] i0, i1;

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Lane0 BEQ rj=3 rd=4 offs16=0xFFFF
    i0 = enc16(6'h16, 16'hFFFF, 5'd3, 5'd4);
    step(0, 1, 1, 2'b01, {32'h0, 32'h1C000100}, {32'h0, i0});
    check_val("beq_aluop", out_aluop[7:0], 8'h50);
    check_val("beq_imm", out_imm[31:0], 32'hFFFFFFFC);
    check_val("beq_reg1", out_reg1_addr[4:0], 5'd3);
    check_val("beq_reg2", out_reg2_addr[4:0], 5'd4);
    check_val("beq_write_en", out_reg_write_en[0], 1'b0);

    // Lane0 BL (offs26=0x10) kills lane1 JIRL and redirects
    i0 = enc26(6'h15, 26'h10);
    i1 = enc16(6'h13, 16'h0008, 5'd7, 5'd9);
    step(0, 1, 1, 2'b11, {32'h1C000004, 32'h1C000000}, {i1, i0});
    check_val("bl_redirect_valid", redirect_valid, 1'b1);
    check_val("bl_redirect_pc", redirect_pc, 32'h1C000040);
    check_val("bl_write_addr", out_reg_write_addr[4:0], 5'd1);
    check_val("bl_lane_valid", out_lane_valid, 2'b01);

    // B with negative offset, then a 3-cycle stall with a pending bundle
    i0 = enc26(6'h14, 26'h3FFFFFC);
    step(0, 1, 1, 2'b01, {32'h0, 32'h00001000}, {32'h0, i0});
    check_val("bneg_redirect_pc", redirect_pc, 32'h00000FF0);
    i0 = enc16(6'h17, 16'h0010, 5'd5, 5'd6);
    i1 = 32'h0000_0000;
    for (int k = 0; k < 3; k++) step(0, 1, 0, 2'b11, {32'h2004, 32'h2000}, {i1, i0});
    step(0, 1, 1, 2'b11, {32'h2004, 32'h2000}, {i1, i0});
    check_val("exc_lane1", out_is_exception, 2'b10);
    check_val("exc_lane1_write_en", out_reg_write_en[1], 1'b0);
    check_val("exc_lane1_read_en", out_reg1_read_en[1], 1'b0);

    // Hold that bundle, then flush alongside an incoming B
    step(0, 0, 0, 2'b00, 64'h0, 64'h0);
    i0 = enc26(6'h14, 26'h100);
    step(1, 1, 0, 2'b01, {32'h0, 32'h3000}, {32'h0, i0});
    check_val("flush_out_valid", out_valid, 1'b0);
    check_val("flush_redirect", redirect_valid, 1'b0);
    step(0, 0, 1, 2'b00, 64'h0, 64'h0);

    // Empty bundle still presented
    step(0, 1, 1, 2'b00, 64'h0, {enc26(6'h14, 26'h4), enc26(6'h14, 26'h4)});
    check_val("empty_lane_valid", out_lane_valid, 2'b00);

    // Lane1 B with 32-bit wrap-around target
    i0 = enc16(6'h18, 16'h0004, 5'd1, 5'd2);
    i1 = enc26(6'h14, 26'h10);
    step(0, 1, 1, 2'b11, {32'hFFFFFFF0, 32'hFFFFFFEC}, {i1, i0});
    check_val("wrap_redirect_pc", redirect_pc, 32'h00000030);

    // Invalid lane0 B must not kill lane1
    i0 = enc26(6'h14, 26'h20);
    i1 = enc16(6'h1B, 16'h8000, 5'd10, 5'd11);
    step(0, 1, 1, 2'b10, {32'h4004, 32'h4000}, {i1, i0});
    check_val("nokill_lane_valid", out_lane_valid, 2'b10);

    // Randomised traffic with back-pressure and occasional flush
    for (int n = 0; n < 80; n++) begin
      step(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom), {32'($urandom) & 32'hFFFFFFFC, 32'($urandom) & 32'hFFFFFFFC},
           {rand_inst(), rand_inst()});
    end

    // Asynchronous reset in the middle of a stall
    step(0, 0, 1, 2'b00, 64'h0, 64'h0);
    i0 = enc26(6'h15, 26'h40);
    step(0, 1, 1, 2'b01, {32'h0, 32'h5000}, {32'h0, i0});
    step(0, 1, 0, 2'b01, {32'h0, 32'h6000}, {32'h0, i0});
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    sb.delete();
    m_ov = 1'b0; m_fresh = 1'b0; m_flushed = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    i0 = enc16(6'h19, 16'h0001, 5'd8, 5'd9);
    step(0, 1, 1, 2'b01, {32'h0, 32'h7000}, {32'h0, i0});
    step(0, 0, 1, 2'b00, 64'h0, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
